// File: rtl/cnt_share_arb_if.sv
// cnt_share_arb_if
// Bundles the requester-facing signals of the shared-counter arbiter.
//
//   req      requesters -> arbiter  per-requester ownership request (level)
//   inc      requesters -> arbiter  per-requester increment strobe
//   gnt      arbiter -> requesters  one-hot grant, all-zero when nobody owns
//   owner    arbiter -> requesters  index of the current owner (valid when busy)
//   busy     arbiter -> requesters  some grant bit is set
//   cnt_clr  arbiter -> counter     one-cycle clear pulse on each new grant
//   cnt_en   arbiter -> counter     increment enable gated to the owner
//   preempt  arbiter -> requesters  one-cycle pulse when a hold timeout revokes a grant
//
// The master modport is the requester/counter side, the slave modport is
// the arbiter itself.
interface cnt_share_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] inc;
    logic [NREQ-1:0] gnt;
    logic [2:0]      owner;
    logic            busy;
    logic            cnt_clr;
    logic            cnt_en;
    logic            preempt;

    modport master (
        output req,
        output inc,
        input  gnt,
        input  owner,
        input  busy,
        input  cnt_clr,
        input  cnt_en,
        input  preempt
    );

    modport slave (
        input  req,
        input  inc,
        output gnt,
        output owner,
        output busy,
        output cnt_clr,
        output cnt_en,
        output preempt
    );
endinterface

// File: rtl/cnt_share_arb.sv
// cnt_share_arb
// Round-robin arbiter that shares one increment counter among NREQ
// requesters. The current owner's inc strobe drives the counter enable,
// every new grant clears the counter, and an owner is forced off after
// MAX_HOLD cycles so nobody starves. A one-cycle gap separates owners so
// the previous owner's inc can never leak into the next owner's count.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-low reset (0 = in reset)
//   bus   cnt_share_arb_if slave modport (req/inc in; gnt, owner, busy,
//         cnt_clr, cnt_en, preempt out)
module cnt_share_arb #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16
) (
    input logic           clk,
    input logic           rst,
    cnt_share_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_q, gnt_nxt;
    logic [2:0]      owner_q, owner_nxt;
    logic [2:0]      last_q, last_nxt;
    logic [7:0]      hold_q, hold_nxt;
    logic            clr_q, clr_nxt;
    logic            pre_q, pre_nxt;

    logic [7:0]      req_ext;
    logic [3:0]      idx;
    logic [2:0]      sel;
    logic            found;
    logic            owner_req;

    // Round-robin search starting just after the last granted requester.
    // The previous owner is therefore examined last, which is what pushes
    // a preempted requester behind everyone else still waiting.
    always_comb begin
        req_ext = 8'(bus.req);
        idx     = '0;
        sel     = last_q;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = {1'b0, last_q} + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!found && req_ext[idx[2:0]]) begin
                sel   = idx[2:0];
                found = 1'b1;
            end
        end
    end

    // gnt is one-hot, so masking req with it picks out req[owner] without
    // a variable index into a vector narrower than the owner field.
    assign owner_req = |(bus.req & gnt_q);

    // Next-state logic. IDLE grants, OWN watches for release or timeout,
    // GAP is the single dead cycle between two owners.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        owner_nxt = owner_q;
        last_nxt  = last_q;
        hold_nxt  = hold_q;
        clr_nxt   = 1'b0;
        pre_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWN;
                    gnt_nxt   = NREQ'(8'd1 << sel);
                    owner_nxt = sel;
                    last_nxt  = sel;
                    hold_nxt  = '0;
                    clr_nxt   = 1'b1;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    // A release on the timeout edge is still only a release.
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                end else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    pre_nxt   = 1'b1;
                end else if (hold_q != 8'(MAX_HOLD)) begin
                    hold_nxt = hold_q + 8'd1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State register. last resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= 3'(NREQ - 1);
            hold_q  <= '0;
            clr_q   <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            owner_q <= owner_nxt;
            last_q  <= last_nxt;
            hold_q  <= hold_nxt;
            clr_q   <= clr_nxt;
            pre_q   <= pre_nxt;
        end
    end

    // cnt_en is the owner's inc bit, masked during the clear cycle so the
    // clear always wins. Because it is built from gnt, an asynchronous
    // reset kills it in the same cycle.
    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = |gnt_q;
    assign bus.cnt_clr = clr_q;
    assign bus.preempt = pre_q;
    assign bus.cnt_en  = |(bus.inc & gnt_q) & ~clr_q;

endmodule

// File: tb/tb_cnt_share_arb.sv
// tb_cnt_share_arb
// Self-checking bench for cnt_share_arb: directed scenarios for reset,
// single ownership, hold timeout, round-robin order, non-owner isolation
// and asynchronous reset, followed by a randomized run compared cycle by
// cycle against a behavioural model of the arbitration rules.
module tb_cnt_share_arb;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    cnt_share_arb_if #(.NREQ(NREQ)) bus ();

    cnt_share_arb #(
        .NREQ    (NREQ),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns, how many cycles they have held,
    // whether we are sitting in the dead cycle, and the pulses this cycle.
    int m_owner = -1;
    int m_last  = NREQ - 1;
    int m_held  = 0;
    bit m_gap   = 1'b0;
    bit m_clr   = 1'b0;
    bit m_pre   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_held  = 0;
            m_gap   = 1'b0;
            m_clr   = 1'b0;
            m_pre   = 1'b0;
        end else begin
            m_clr = 1'b0;
            m_pre = 1'b0;
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_owner < 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_last + k) % NREQ;
                    if (m_owner < 0 && bus.req[c]) begin
                        m_owner = c;
                        m_last  = c;
                        m_held  = 1;
                        m_clr   = 1'b1;
                    end
                end
            end else if (!bus.req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_held == MAX_HOLD) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_pre   = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic exp_en();
        if (m_owner < 0) return 1'b0;
        return bus.inc[m_owner] && !m_clr;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        bus.req = '0;
        bus.inc = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        bus.req = 4'b1111;
        bus.inc = '0;
        repeat (2) tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.gnt);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.cnt_clr !== 1'b0 || bus.preempt !== 1'b0 || bus.owner !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got busy=%b clr=%b pre=%b owner=%0d expected all 0",
                     bus.busy, bus.cnt_clr, bus.preempt, bus.owner);
        end
        rst = 1'b1;
        tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.cnt_clr !== 1'b1 || bus.owner !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_first_grant: got gnt=%b clr=%b owner=%0d expected 0001 1 0",
                     bus.gnt, bus.cnt_clr, bus.owner);
        end
        tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.cnt_clr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_clr_pulse: got gnt=%b clr=%b expected 0001 0", bus.gnt, bus.cnt_clr);
        end
        settle();
    endtask

    task automatic test_single_owner();
        int en_cnt;
        int pre_cnt;
        en_cnt  = 0;
        pre_cnt = 0;
        bus.req = 4'b0100;
        bus.inc = 4'b0100;
        tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0100 || bus.cnt_clr !== 1'b1 || bus.cnt_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_grant: got gnt=%b clr=%b en=%b expected 0100 1 0",
                     bus.gnt, bus.cnt_clr, bus.cnt_en);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            if (bus.cnt_en === 1'b1) en_cnt++;
            if (bus.preempt === 1'b1) pre_cnt++;
        end
        bus.req = 4'b0000;
        tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.cnt_en !== 1'b0 || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_release: got gnt=%b busy=%b en=%b pre=%b expected 0000 0 0 0",
                     bus.gnt, bus.busy, bus.cnt_en, bus.preempt);
        end
        vectors++;
        if (en_cnt != 4 || pre_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL single_en_count: got en=%0d pre=%0d expected 4 0", en_cnt, pre_cnt);
        end
        settle();
    endtask

    task automatic test_timeout();
        int held;
        int pre_cnt;
        bus.req = 4'b0011;
        bus.inc = '0;
        tick();
        #1;
        held    = (bus.gnt === 4'b0001) ? 1 : 0;
        pre_cnt = 0;
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            #1;
            if (bus.gnt === 4'b0001) held++;
            if (bus.preempt === 1'b1) pre_cnt++;
        end
        tick();
        #1;
        if (bus.preempt === 1'b1) pre_cnt++;
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_revoke: got gnt=%b pre=%b expected 0000 1", bus.gnt, bus.preempt);
        end
        tick();
        #1;
        if (bus.preempt === 1'b1) pre_cnt++;
        vectors++;
        if (bus.gnt !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL timeout_gap: got gnt=%b expected 0000", bus.gnt);
        end
        tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0010 || bus.cnt_clr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_next_owner: got gnt=%b clr=%b expected 0010 1", bus.gnt, bus.cnt_clr);
        end
        vectors++;
        if (held != MAX_HOLD || pre_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL timeout_hold_len: got held=%0d pre=%0d expected %0d 1", held, pre_cnt, MAX_HOLD);
        end
        settle();
    endtask

    task automatic test_round_robin();
        bit found;
        rst     = 1'b0;
        bus.req = '0;
        bus.inc = '0;
        tick();
        rst     = 1'b1;
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            found = 1'b0;
            for (int w = 0; w < 4 && !found; w++) begin
                tick();
                #1;
                if (bus.busy === 1'b1) found = 1'b1;
            end
            vectors++;
            if (!found || bus.owner !== 3'(n % NREQ) || bus.gnt !== 4'(1 << (n % NREQ))) begin
                miscompares++;
                $display("[TB] FAIL rr_order_%0d: got busy=%b owner=%0d gnt=%b expected owner %0d",
                         n, bus.busy, bus.owner, bus.gnt, n % NREQ);
            end
            repeat (2) tick();
            bus.req = 4'b1111 & ~(4'b0001 << bus.owner);
            tick();
            #1;
            vectors++;
            if (bus.gnt !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL rr_release_%0d: got gnt=%b expected 0000", n, bus.gnt);
            end
            bus.req = 4'b1111;
        end
        settle();
    endtask

    task automatic test_isolation();
        int en_seen;
        en_seen = 0;
        bus.req = 4'b0010;
        bus.inc = 4'b1101;
        tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0010 || bus.owner !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL iso_grant: got gnt=%b owner=%0d expected 0010 1", bus.gnt, bus.owner);
        end
        if (bus.cnt_en === 1'b1) en_seen++;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            if (bus.cnt_en === 1'b1) en_seen++;
        end
        vectors++;
        if (en_seen != 0) begin
            miscompares++;
            $display("[TB] FAIL iso_non_owner: got %0d enabled cycles expected 0", en_seen);
        end
        bus.inc = 4'b0010;
        #1;
        vectors++;
        if (bus.cnt_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL iso_owner_inc: got en=%b expected 1", bus.cnt_en);
        end
        settle();
    endtask

    task automatic test_async_reset();
        bus.req = 4'b0100;
        bus.inc = 4'b0100;
        tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL areset_setup: got gnt=%b expected 0100", bus.gnt);
        end
        tick();
        #1;
        vectors++;
        if (bus.cnt_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL areset_en_before: got en=%b expected 1", bus.cnt_en);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.cnt_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL areset_immediate: got gnt=%b busy=%b en=%b expected 0000 0 0",
                     bus.gnt, bus.busy, bus.cnt_en);
        end
        bus.req = 4'b1111;
        tick();
        rst = 1'b1;
        tick();
        #1;
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.owner !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL areset_restart: got gnt=%b owner=%0d expected 0001 0", bus.gnt, bus.owner);
        end
        settle();
    endtask

    task automatic test_random();
        bus.req = 4'($urandom_range(0, 15));
        bus.inc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 9) == 0) bus.req[b] = ~bus.req[b];
            end
            bus.inc = 4'($urandom_range(0, 15));
            #1;
            vectors++;
            if (bus.gnt !== exp_gnt() || !$onehot0(bus.gnt)) begin
                miscompares++;
                $display("[TB] FAIL rand_gnt@%0d: got %b expected %b", cyc, bus.gnt, exp_gnt());
            end
            vectors++;
            if (bus.busy !== (m_owner >= 0) || (m_owner >= 0 && bus.owner !== 3'(m_owner))) begin
                miscompares++;
                $display("[TB] FAIL rand_owner@%0d: got busy=%b owner=%0d expected owner %0d",
                         cyc, bus.busy, bus.owner, m_owner);
            end
            vectors++;
            if (bus.cnt_clr !== m_clr || bus.preempt !== m_pre) begin
                miscompares++;
                $display("[TB] FAIL rand_pulses@%0d: got clr=%b pre=%b expected %b %b",
                         cyc, bus.cnt_clr, bus.preempt, m_clr, m_pre);
            end
            vectors++;
            if (bus.cnt_en !== exp_en()) begin
                miscompares++;
                $display("[TB] FAIL rand_en@%0d: got %b expected %b", cyc, bus.cnt_en, exp_en());
            end
        end
        settle();
    endtask

    initial begin
        bus.req = '0;
        bus.inc = '0;
        $display("[TB] starting cnt_share_arb bench");
        test_reset();
        test_single_owner();
        test_timeout();
        test_round_robin();
        test_isolation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cnt_share_arb.md
Name: cnt_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one free-running increment counter datapath among NREQ requesters.
- The counter datapath is the 8-bit cnt/cnt+1 register path.
- The block grants ownership, gates the counter's increment enable to the current owner, and pulses a counter clear on each new grant.
- It enforces a maximum hold time so no requester can starve the others.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_HOLD, 16, maximum cycles one owner may hold the grant (2..255).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- req  input  NREQ  per-requester ownership request; level, held until done.
- inc  input  NREQ  per-requester increment strobe; honoured only for the current owner.
- gnt  output  NREQ  one-hot grant, registered; all-zero when no owner.
- owner  output  3  index of current owner; valid only while busy=1.
- busy  output  1  1 while some gnt bit is set.
- cnt_clr  output  1  registered one-cycle pulse that clears the shared counter on each new grant.
- cnt_en  output  1  combinational increment enable: busy & inc[owner] & ~cnt_clr.
- preempt  output  1  registered one-cycle pulse when a grant is revoked by hold timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt=0, owner=0, busy=0, cnt_clr=0, preempt=0.
  - State=IDLE, hold_cnt=0, last=NREQ-1, so requester 0 has first priority.
  - Deasserting rst synchronously to clk is the system's responsibility.
- FSM states: IDLE, OWN, GAP.
- IDLE:
  - If req != 0 at edge k, choose the first set bit searching last+1, last+2, … modulo NREQ.
  - From edge k: state=OWN, gnt=onehot(sel), owner=sel, busy=1, cnt_clr=1 for exactly one cycle, hold_cnt=0, last=sel.
  - Grant latency is 1 cycle from req sampled high.
- OWN:
  - Each cycle hold_cnt increments (saturating at MAX_HOLD).
  - cnt_en follows inc[owner] combinationally. It is forced 0 during the cnt_clr cycle so clear wins over increment.
  - inc from non-owners is ignored.
  - If req[owner]=0 at an edge: go to GAP; gnt=0, busy=0 from that edge.
  - Else if hold_cnt==MAX_HOLD-1 at an edge: go to GAP; gnt=0, busy=0, preempt=1 for one cycle.
  - The owner therefore holds for at most MAX_HOLD cycles, including the clear cycle.
  - A release and a timeout on the same edge count as a release only: preempt=0.
- GAP:
  - Exactly one idle cycle with gnt=0, so the old owner's inc cannot reach the new owner.
  - Next edge returns to IDLE; arbitration happens on the following edge.
  - Owner-to-owner turnaround is 2 cycles.
- Round robin:
  - last is updated only on grant.
  - A preempted requester still requesting is searched last, after all others.
  - If it is the only requester, it is regranted after GAP and receives a fresh cnt_clr.
- Requests:
  - A request dropped before grant is simply not selected; no memory of past requests.
  - req changes during GAP have no effect until the IDLE edge.
- Invariants: gnt is zero or one-hot; busy == |gnt; owner is stable for the entire OWN interval.
- Reset mid-OWN: gnt drops immediately (asynchronously) and cnt_en becomes 0 in the same cycle.

Test Plan:
1. Reset with req=4'b1111 -> gnt=0 during reset. First edge after release: gnt=0001, cnt_clr=1 for one cycle, owner=0.
2. Single owner: req=0100, inc[2]=1 for 5 cycles after grant, then drop req[2] -> cnt_en high exactly 4 cycles (clear cycle masked). gnt=0 at the drop edge. No preempt.
3. Timeout with MAX_HOLD=16: req=0001 held forever and req=0010 also held -> requester 0 holds 16 cycles, preempt pulses once. One GAP cycle, then gnt=0010 with cnt_clr.
4. Round-robin order: req=1111 held, each owner releases after 3 cycles -> grant sequence 0,1,2,3,0.
5. Non-owner isolation: owner=1, inc=1101 -> cnt_en=0 throughout. Then inc[1]=1 -> cnt_en=1.
6. Async reset mid-OWN: rst=0 between edges while gnt=0100 -> gnt, busy, cnt_en go to 0 before the next edge. Restart grants requester 0 first.
